// File: rtl/cu_fsm_mc.sv
`default_nettype none
// ============================================================================
//  Module   : cu_fsm_mc
//  Purpose  : Multicycle control unit for the RV32 core. Sequences
//             fetch / execute / load / store / writeback with a memReady
//             handshake, a memory wait timeout that raises a bus-error trap,
//             interrupt entry, CSR-write decode and an MRET strobe.
//  Ports    : CLK, RST (sync, active high)
//             INT, intEn          - interrupt request / global enable
//             ir, csrStuff        - opcode and funct3 of current instruction
//             memReady            - shared memory acknowledge
//             pcWrite, regWrite, memWrite, memRead1, memRead2, csrWrite,
//             intTaken, mretTaken, busErr, execute - datapath enables
//             instret             - retired-instruction counter
//  Options  : CU_FSM_INSTRET_EN - when defined, instret counts retired
//             non-trap instructions; otherwise it is tied to zero.
//  Revision : 1.0 - initial release
// ============================================================================
module cu_fsm_mc #(
  parameter int OPCODE_W    = 7,
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = $clog2(MEM_TIMEOUT + 1)
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                INT,
  input  logic                intEn,
  input  logic [OPCODE_W-1:0] ir,
  input  logic [2:0]          csrStuff,
  input  logic                memReady,
  output logic                pcWrite,
  output logic                regWrite,
  output logic                memWrite,
  output logic                memRead1,
  output logic                memRead2,
  output logic                csrWrite,
  output logic                intTaken,
  output logic                mretTaken,
  output logic                busErr,
  output logic                execute,
  output logic [31:0]         instret
);

  // A zero timeout yields a zero-width counter; keep at least one bit.
  localparam int c_cnt_w = (CNT_W < 1) ? 1 : CNT_W;

  localparam logic [2:0] c_fetch     = 3'd0;
  localparam logic [2:0] c_execute   = 3'd1;
  localparam logic [2:0] c_load      = 3'd2;
  localparam logic [2:0] c_store     = 3'd3;
  localparam logic [2:0] c_writeback = 3'd4;
  localparam logic [2:0] c_interrupt = 3'd5;
  localparam logic [2:0] c_buserr    = 3'd6;

  localparam logic [OPCODE_W-1:0] c_op_store  = OPCODE_W'(7'b0100011);
  localparam logic [OPCODE_W-1:0] c_op_load   = OPCODE_W'(7'b0000011);
  localparam logic [OPCODE_W-1:0] c_op_branch = OPCODE_W'(7'b1100011);
  localparam logic [OPCODE_W-1:0] c_op_system = OPCODE_W'(7'b1110011);

  localparam logic [c_cnt_w-1:0] c_tmo_max = c_cnt_w'(MEM_TIMEOUT);
  localparam logic [c_cnt_w-1:0] c_tmo_m1  = c_cnt_w'(MEM_TIMEOUT - 1);

  logic [2:0]         r_ps;
  logic [2:0]         w_ns;
  logic [c_cnt_w-1:0] r_wait_cnt;
  logic               w_timeout;
  logic               w_wait_state;

  // Timeout fires on the last allowed wait cycle; an acknowledge in the
  // same cycle takes precedence.
  assign w_timeout    = (MEM_TIMEOUT != 0) && (r_wait_cnt == c_tmo_m1) && !memReady;
  assign w_wait_state = (r_ps == c_fetch) || (r_ps == c_load) || (r_ps == c_store);

  always_comb begin
    w_ns      = r_ps;
    pcWrite   = 1'b0;
    regWrite  = 1'b0;
    memWrite  = 1'b0;
    memRead1  = 1'b0;
    memRead2  = 1'b0;
    csrWrite  = 1'b0;
    intTaken  = 1'b0;
    mretTaken = 1'b0;
    busErr    = 1'b0;
    execute   = 1'b0;
    case (r_ps)
      c_fetch: begin
        memRead1 = 1'b1;
        if (memReady) begin
          execute = 1'b1;
          w_ns    = c_execute;
        end else if (w_timeout) begin
          w_ns = c_buserr;
        end
      end
      c_execute: begin
        if (INT && intEn) begin
          intTaken = 1'b1;
          w_ns     = c_interrupt;
        end else if (ir == c_op_store) begin
          memWrite = 1'b1;
          w_ns     = c_store;
        end else if (ir == c_op_load) begin
          memRead2 = 1'b1;
          w_ns     = c_load;
        end else if (ir == c_op_branch) begin
          pcWrite = 1'b1;
          w_ns    = c_fetch;
        end else if (ir == c_op_system) begin
          pcWrite   = 1'b1;
          csrWrite  = (csrStuff[1:0] != 2'b00);
          mretTaken = (csrStuff == 3'b000);
          w_ns      = c_fetch;
        end else begin
          regWrite = 1'b1;
          pcWrite  = 1'b1;
          w_ns     = c_fetch;
        end
      end
      c_store: begin
        // The request stays up through the timeout cycle; only the
        // completion enables are withheld.
        memWrite = 1'b1;
        if (memReady) begin
          pcWrite = 1'b1;
          w_ns    = c_fetch;
        end else if (w_timeout) begin
          w_ns = c_buserr;
        end
      end
      c_load: begin
        memRead2 = 1'b1;
        if (memReady) begin
          w_ns = c_writeback;
        end else if (w_timeout) begin
          w_ns = c_buserr;
        end
      end
      c_writeback: begin
        regWrite = 1'b1;
        pcWrite  = 1'b1;
        w_ns     = c_fetch;
      end
      c_interrupt: begin
        intTaken = 1'b1;
        pcWrite  = 1'b1;
        w_ns     = c_fetch;
      end
      c_buserr: begin
        busErr   = 1'b1;
        intTaken = 1'b1;
        pcWrite  = 1'b1;
        w_ns     = c_fetch;
      end
      default: begin
        w_ns = c_fetch;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_ps       <= c_fetch;
      r_wait_cnt <= '0;
    end else begin
      r_ps <= w_ns;
      if (w_ns != r_ps) begin
        r_wait_cnt <= '0;
      end else if (w_wait_state && !memReady && (r_wait_cnt != c_tmo_max)) begin
        r_wait_cnt <= r_wait_cnt + c_cnt_w'(1);
      end
    end
  end

`ifdef CU_FSM_INSTRET_EN
  logic [31:0] r_instret;
  logic        w_retire;

  // Only ordinary completions retire; trap states also raise pcWrite but
  // must not be counted.
  assign w_retire = pcWrite &&
                    ((r_ps == c_execute) || (r_ps == c_store) || (r_ps == c_writeback));

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_instret <= 32'h0;
    end else if (w_retire) begin
      r_instret <= r_instret + 32'h1;
    end
  end

  assign instret = r_instret;
`else
  assign instret = 32'h0;
`endif

endmodule
`default_nettype wire

// File: doc/cu_fsm_mc.md
Name: cu_fsm_mc

Overview:
Parametrised multicycle control unit for the RV32 core. It replaces the fixed-latency fetch/execute sequencer with one that handshakes with variable-latency instruction and data memory through a shared `memReady` acknowledge. It adds separate store and writeback states, a memory timeout that raises a bus-error trap, full CSR-write decode, and an MRET strobe. It sits between the IR/decoder and the PC, register file, memory and CSR enables.

Parameters:
- OPCODE_W, 7, width of the `ir` opcode field.
- MEM_TIMEOUT, 15, maximum cycles spent waiting for `memReady` in any wait state. 0 disables the timeout.
- CNT_W, $clog2(MEM_TIMEOUT+1), width of the wait counter. Derived; do not override.

Ports:
- CLK  in  1  core clock.
- RST  in  1  synchronous active-high reset.
- INT  in  1  interrupt request (level).
- intEn  in  1  global interrupt enable (mstatus.MIE).
- ir  in  OPCODE_W  opcode of the current instruction.
- csrStuff  in  3  funct3 of the current instruction.
- memReady  in  1  memory acknowledge for the current read/write.
- pcWrite  out  1  PC update enable.
- regWrite  out  1  register file write enable.
- memWrite  out  1  data memory write request.
- memRead1  out  1  instruction fetch request.
- memRead2  out  1  data read request.
- csrWrite  out  1  CSR write enable.
- intTaken  out  1  interrupt entry (mepc/mcause save, vector select).
- mretTaken  out  1  MRET executing.
- busErr  out  1  memory timeout trap.
- execute  out  1  IR latch enable.
- instret  out  32  retired-instruction count (see Optional Feature).

Behaviour:
- Registered state: PS and waitCnt. All outputs are combinational from PS and the inputs. Every output defaults to 0 in every state unless listed below.
- Reset: while RST=1 at a CLK edge, PS←FETCH, waitCnt←0, instret←0. In the cycle after reset the outputs are the FETCH values: memRead1=1, all others 0 (execute=1 only if memReady=1).
- States: FETCH, EXECUTE, LOAD, STORE, WRITEBACK, INTERRUPT, BUSERR.
- FETCH:
  - memRead1=1.
  - memReady=1: execute=1, NS=EXECUTE.
  - Otherwise: stay in FETCH and count waitCnt.
- EXECUTE: checks are taken in this priority order.
  1. INT & intEn: intTaken=1, NS=INTERRUPT.
  2. Store (0100011): memWrite=1, NS=STORE.
  3. Load (0000011): memRead2=1, NS=LOAD.
  4. Branch (1100011): pcWrite=1, NS=FETCH.
  5. System (1110011): pcWrite=1, NS=FETCH.
     - csrWrite=1 when csrStuff[1:0]≠00 (CSRRW/S/C and the immediate forms).
     - mretTaken=1 when csrStuff=000 (MRET).
  6. Any other opcode: regWrite=1, pcWrite=1, NS=FETCH.
- STORE:
  - memWrite=1 held until memReady.
  - On memReady: pcWrite=1, NS=FETCH.
- LOAD:
  - memRead2=1 held until memReady.
  - On memReady: NS=WRITEBACK.
- WRITEBACK: regWrite=1, pcWrite=1, NS=FETCH.
- INTERRUPT: intTaken=1, pcWrite=1, NS=FETCH.
- BUSERR: busErr=1, intTaken=1, pcWrite=1 (trap vector), NS=FETCH.
- INT sampling:
  - INT is sampled only in EXECUTE. It is ignored in FETCH, LOAD, STORE and WRITEBACK; the memory transaction always completes first.
  - INT=1 with intEn=0: normal decode.
- Wait counter:
  - waitCnt clears on every state change.
  - In FETCH/LOAD/STORE with memReady=0 it increments, saturating at MEM_TIMEOUT.
  - If MEM_TIMEOUT≠0, waitCnt=MEM_TIMEOUT-1 and memReady=0: NS=BUSERR. No write enable asserts in that cycle.
  - memReady=1 on the timeout cycle: the acknowledge wins.
- memReady arriving in the same cycle a request first asserts is a valid zero-wait transfer.
- memReady is ignored in EXECUTE, WRITEBACK, INTERRUPT and BUSERR.
- RST mid-transaction: PS returns to FETCH on the next edge. The pending request drops without a write enable.

Optional Feature:
- Macro: CU_FSM_INSTRET_EN.
- Defined:
  - instret increments by 1 on each CLK edge where a non-trap instruction retires: pcWrite=1 in EXECUTE, STORE or WRITEBACK.
  - It does not increment for INTERRUPT or BUSERR.
  - It wraps 0xFFFFFFFF→0 and clears on RST.
- Undefined: instret is tied to 32'h0 and no counter logic is generated.

Test Plan:
- R-type (ir=0110011), memReady=1 in FETCH → execute=1 in cycle 1; cycle 2 regWrite=pcWrite=1; back to FETCH; instret=1 (macro on).
- Load, memReady delayed 3 cycles in LOAD → memRead2 held 4 cycles, then one WRITEBACK cycle with regWrite=pcWrite=1; no regWrite before that.
- Store, memReady never asserted, MEM_TIMEOUT=15 → memWrite held 15 cycles, then BUSERR with busErr=intTaken=pcWrite=1; next FETCH; instret unchanged.
- INT=1 during LOAD wait, intEn=1 → load completes via WRITEBACK; next EXECUTE gives intTaken=1, NS=INTERRUPT, pcWrite=1; no regWrite for that instruction.
- System opcode with csrStuff=001, 010, 000 → csrWrite=1, csrWrite=1, and mretTaken=1 with csrWrite=0, respectively; pcWrite=1 in each case.
- RST=1 while in STORE with memWrite=1 → next cycle PS=FETCH, memWrite=0, memRead1=1, waitCnt=0, instret=0.
